maxpool2x2_axis: RTL and testbench
==================================

Name: maxpool2x2_axis

Overview:
Downstream stage of the conv2D AXI-Stream engine. Consumes its 16-bit signed result stream (row-major, one feature map per packet) and performs 2x2 stride-2 max pooling. Emits one 16-bit word per window on an AXI-Stream master toward DRAM. Uses a half-width line buffer and a registered output with backpressure.

Parameters:
MAX_W, 416, maximum feature-map width in pixels (even)
MAX_H, 416, maximum feature-map height in pixels (even)
DW, 16, data width (signed two's complement)

Ports:
S_AXIS_ACLK  in  1  single clock for both streams
S_AXIS_ARESETN  in  1  asynchronous active-low reset
cfg_width  in  $clog2(MAX_W+1)  map width, even, latched on the first accepted beat of a frame
cfg_height  in  $clog2(MAX_H+1)  map height, even, latched with cfg_width
S_AXIS_TDATA  in  DW  input pixel
S_AXIS_TKEEP  in  2  byte enables
S_AXIS_TLAST  in  1  last pixel of map
S_AXIS_TVALID  in  1  input valid
S_AXIS_TREADY  out  1  input ready
M_AXIS_TDATA  out  DW  pooled pixel
M_AXIS_TKEEP  out  2  constant 2'b11
M_AXIS_TLAST  out  1  last pooled pixel of map
M_AXIS_TVALID  out  1  output valid
M_AXIS_TREADY  in  1  downstream ready
err_tlast  out  1  sticky: TLAST position mismatch

Behaviour:
- Reset (async, ARESETN=0): state=IDLE; col, row counters=0; M_AXIS_TVALID=0; M_AXIS_TLAST=0; M_AXIS_TDATA=0; err_tlast=0. The line buffer is not cleared.
- RX = S_AXIS_TVALID && S_AXIS_TREADY. Beats with TKEEP != 2'b11 are consumed and discarded: no counter or state change.
- S_AXIS_TREADY = (state != DRAIN) && (!M_AXIS_TVALID || M_AXIS_TREADY).
- States:
  - IDLE: on the first data beat, latch cfg, process the beat as pixel (0,0), go to RUN.
  - RUN: process beats. After the expected final pixel (row=H-1, col=W-1) is accepted, go to DRAIN.
  - DRAIN: when the output handshake completes, go to IDLE.
- Pixel handling at (row, col):
  - Even col: hold the pixel in h_reg.
  - Odd col: hmax = signed max(h_reg, pixel).
  - Even row, odd col: write hmax to linebuf[col>>1].
  - Odd row, odd col: out = max(hmax, linebuf[col>>1]). Load the output register; M_AXIS_TVALID=1 the next cycle (latency 1 cycle from the window's bottom-right beat).
- Output register holds its contents while M_AXIS_TVALID && !M_AXIS_TREADY. A new load and a drain in the same cycle are allowed. No word is lost or duplicated.
- M_AXIS_TLAST=1 exactly on window (H/2-1, W/2-1).
- Counters: col wraps W-1 -> 0 and increments row. row wraps only at frame end.
- Ties in max: either operand (values equal).
- TLAST checks:
  - TLAST on an accepted data beat before the final pixel: set err_tlast; discard any partial window; go to IDLE. Already emitted words are unaffected, and no TLAST is emitted.
  - Final pixel without TLAST: set err_tlast; end the frame normally (go to DRAIN, TLAST generated).
- Reset mid-frame aborts immediately. Any pending output word is lost.
- cfg changes during RUN are ignored. Odd or zero cfg values are illegal and behaviour is undefined.

Optional Feature:
MAXPOOL_RELU_EN:
- Defined: the output register is loaded with max(out, 0), giving fused ReLU; the negative result becomes 16'h0000.
- Undefined: the output is the raw signed max. Timing is identical in both cases.

Decomposition:
- Package yolo_stream_pkg: DW, the state enum (IDLE/RUN/DRAIN), the MAX_W/MAX_H defaults and a signed max function. The package is shared with conv2D-family stages.
- One sub-module: maxpool_linebuf, a single-port MAX_W/2 x DW buffer with synchronous write and combinational read.

Test Plan:
- 4x4 map with values 1..16 row-major, no backpressure -> output 6, 8, 14, 16; TLAST on 16; err_tlast=0.
- Same map with M_AXIS_TREADY toggling 1 of 3 cycles -> identical output sequence, S_AXIS_TREADY stalls, no drops.
- 2x2 map {-5, -3, -7, -9} -> output -3 (16'hFFFD) without MAXPOOL_RELU_EN, 0 with it.
- 4x4 map with TLAST on pixel 9 -> output 6, 8 only, no M_AXIS_TLAST, err_tlast=1; the next clean 2x2 frame {1, 2, 3, 4} -> output 4 with TLAST.
- Assert ARESETN low mid-frame on pixel 6 -> M_AXIS_TVALID=0 and state IDLE immediately; a subsequent 2x2 frame {4, 1, 1, 1} -> output 4 with TLAST.
- Beats with TKEEP=2'b00 interleaved into a 4x4 frame -> ignored; results equal to the first scenario.

Source files
------------

// File: rtl/yolo_stream_pkg.sv
// Shared types and helpers for the conv2D-family AXI-Stream stages.
package yolo_stream_pkg;

   localparam int DW            = 16;
   localparam int MAX_W_DEFAULT = 416;
   localparam int MAX_H_DEFAULT = 416;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } stream_state_e;

   function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// Half-width line buffer holding the horizontal maxima of the upper row of each window pair.
module maxpool_linebuf #(
   parameter int DEPTH = 208,
   parameter int WIDTH = 16,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/maxpool2x2_axis.sv
// 2x2 stride-2 max pooling over a row-major AXI-Stream feature map, one word per window out.
// Optional fused ReLU on the output: define MAXPOOL_RELU_EN.
module maxpool2x2_axis
   import yolo_stream_pkg::*;
#(
   parameter int MAX_W = MAX_W_DEFAULT,
   parameter int MAX_H = MAX_H_DEFAULT
) (
   input  logic                         S_AXIS_ACLK,
   input  logic                         S_AXIS_ARESETN,
   input  logic [$clog2(MAX_W+1)-1:0]   cfg_width,
   input  logic [$clog2(MAX_H+1)-1:0]   cfg_height,
   input  logic [DW-1:0]                S_AXIS_TDATA,
   input  logic [1:0]                   S_AXIS_TKEEP,
   input  logic                         S_AXIS_TLAST,
   input  logic                         S_AXIS_TVALID,
   output logic                         S_AXIS_TREADY,
   output logic [DW-1:0]                M_AXIS_TDATA,
   output logic [1:0]                   M_AXIS_TKEEP,
   output logic                         M_AXIS_TLAST,
   output logic                         M_AXIS_TVALID,
   input  logic                         M_AXIS_TREADY,
   output logic                         err_tlast
);

   localparam int CW = $clog2(MAX_W+1);
   localparam int RW = $clog2(MAX_H+1);
   localparam int AW = $clog2(MAX_W/2);

   stream_state_e         state, state_nxt;
   logic [CW-1:0]         col, w_q, cur_w;
   logic [RW-1:0]         row, h_q, cur_h;
   logic signed [DW-1:0]  h_reg, pix, hmax, vmax, pool, lb_rdata;
   logic [AW-1:0]         lb_addr;
   logic                  data_beat, last_col, final_px, early_last, pix_ok;
   logic                  lb_we, out_load;
   logic                  m_valid, m_last, err_q;
   logic [DW-1:0]         m_data;

   assign S_AXIS_TREADY = (state != DRAIN) && (!m_valid || M_AXIS_TREADY);
   assign M_AXIS_TDATA  = m_data;
   assign M_AXIS_TKEEP  = 2'b11;
   assign M_AXIS_TLAST  = m_last;
   assign M_AXIS_TVALID = m_valid;
   assign err_tlast     = err_q;

   // In IDLE the first beat is checked against the live cfg, since the latch lands a cycle later.
   always_comb begin
      cur_w      = (state == IDLE) ? cfg_width  : w_q;
      cur_h      = (state == IDLE) ? cfg_height : h_q;
      data_beat  = S_AXIS_TVALID && S_AXIS_TREADY && (S_AXIS_TKEEP == 2'b11);
      last_col   = (col == cur_w - CW'(1));
      final_px   = last_col && (row == cur_h - RW'(1));
      early_last = data_beat && S_AXIS_TLAST && !final_px;
      pix_ok     = data_beat && !early_last;
      pix        = S_AXIS_TDATA;
      hmax       = smax(h_reg, pix);
      vmax       = smax(hmax, lb_rdata);
`ifdef MAXPOOL_RELU_EN
      pool       = vmax[DW-1] ? '0 : vmax;
`else
      pool       = vmax;
`endif
      lb_addr    = AW'(col >> 1);
      lb_we      = pix_ok && !row[0] && col[0];
      out_load   = pix_ok &&  row[0] && col[0];
   end

   maxpool_linebuf #(
      .DEPTH (MAX_W/2),
      .WIDTH (DW),
      .AW    (AW)
   ) u_linebuf (
      .clk   (S_AXIS_ACLK),
      .we    (lb_we),
      .addr  (lb_addr),
      .wdata (hmax),
      .rdata (lb_rdata)
   );

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) state <= IDLE;
      else                 state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pix_ok) state_nxt = final_px ? DRAIN : RUN;
         end
         RUN: begin
            if (early_last)              state_nxt = IDLE;
            else if (pix_ok && final_px) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (m_valid && M_AXIS_TREADY) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Position counters, cfg latch and the even-column holding register.
   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         col   <= '0;
         row   <= '0;
         w_q   <= '0;
         h_q   <= '0;
         h_reg <= '0;
      end else begin
         if (state == IDLE && data_beat) begin
            w_q <= cfg_width;
            h_q <= cfg_height;
         end
         if (early_last) begin
            col <= '0;
            row <= '0;
         end else if (pix_ok) begin
            if (!col[0]) h_reg <= pix;
            if (final_px) begin
               col <= '0;
               row <= '0;
            end else if (last_col) begin
               col <= '0;
               row <= row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end

   // A load may coincide with the downstream taking the previous word.
   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         m_data  <= '0;
         err_q   <= 1'b0;
      end else begin
         if (out_load) begin
            m_valid <= 1'b1;
            m_data  <= pool;
            m_last  <= final_px;
         end else if (M_AXIS_TREADY) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
         if (early_last || (pix_ok && final_px && !S_AXIS_TLAST)) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_maxpool2x2_axis.sv
// Scoreboard bench for maxpool2x2_axis: window-level reference model feeds a queue, a monitor drains it.
module tb_maxpool2x2_axis;
   import yolo_stream_pkg::*;

   localparam int CW = $clog2(MAX_W_DEFAULT+1);
   localparam int RW = $clog2(MAX_H_DEFAULT+1);

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [CW-1:0]  cfg_width = '0;
   logic [RW-1:0]  cfg_height = '0;
   logic [15:0]    s_tdata = '0;
   logic [1:0]     s_tkeep = '0;
   logic           s_tlast = 1'b0;
   logic           s_tvalid = 1'b0;
   logic           s_tready;
   logic [15:0]    m_tdata;
   logic [1:0]     m_tkeep;
   logic           m_tlast;
   logic           m_tvalid;
   logic           m_tready = 1'b1;
   logic           err_tlast;

   maxpool2x2_axis dut (
      .S_AXIS_ACLK    (clk),
      .S_AXIS_ARESETN (rst_n),
      .cfg_width      (cfg_width),
      .cfg_height     (cfg_height),
      .S_AXIS_TDATA   (s_tdata),
      .S_AXIS_TKEEP   (s_tkeep),
      .S_AXIS_TLAST   (s_tlast),
      .S_AXIS_TVALID  (s_tvalid),
      .S_AXIS_TREADY  (s_tready),
      .M_AXIS_TDATA   (m_tdata),
      .M_AXIS_TKEEP   (m_tkeep),
      .M_AXIS_TLAST   (m_tlast),
      .M_AXIS_TVALID  (m_tvalid),
      .M_AXIS_TREADY  (m_tready),
      .err_tlast      (err_tlast)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   err_exp = 1'b0;
   int   bp_mode = 0;
   int   px[0:255];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Downstream ready pattern: 0 = always, 1 = one cycle in three, 2 = random.
   always @(posedge clk) begin : bp_gen
      int cyc;
      #1;
      case (bp_mode)
         1:       m_tready = ((cyc % 3) == 0);
         2:       m_tready = ($urandom_range(0, 1) == 1);
         default: m_tready = 1'b1;
      endcase
      cyc++;
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && m_tvalid && m_tready) begin
         if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got %0h last=%0b, expected none", m_tdata, m_tlast);
         end else begin
            e = sbq.pop_front();
            check("tdata", m_tdata, e.data);
            check("tlast", m_tlast, e.last);
            check("tkeep", m_tkeep, 2'b11);
         end
      end
   end

   // Reference: each window's max over its four pixels; a window whose bottom-right beat
   // is at or after an early-TLAST beat never appears.
   task automatic push_expected(input int w, input int h, input int abort_idx, input bit final_tlast);
      int a, b, c, d, m, br;
      exp_t e;
      for (int i = 0; i < h/2; i++) begin
         for (int j = 0; j < w/2; j++) begin
            br = (2*i+1)*w + 2*j + 1;
            if (abort_idx >= 0 && br >= abort_idx) continue;
            a = px[(2*i)*w + 2*j];
            b = px[(2*i)*w + 2*j + 1];
            c = px[(2*i+1)*w + 2*j];
            d = px[(2*i+1)*w + 2*j + 1];
            m = a;
            if (b > m) m = b;
            if (c > m) m = c;
            if (d > m) m = d;
`ifdef MAXPOOL_RELU_EN
            if (m < 0) m = 0;
`endif
            e.data = 16'(m);
            e.last = (abort_idx < 0) && (i == h/2-1) && (j == w/2-1);
            sbq.push_back(e);
         end
      end
      if (abort_idx >= 0 || !final_tlast) err_exp = 1'b1;
   endtask

   // Called just after a rising edge; returns just after the edge that took the beat.
   task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
      bit ok;
      int t;
      t = 0;
      s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
      do begin
         @(negedge clk);
         ok = s_tready;
         @(posedge clk);
         #1;
         t++;
      end while (!ok && t < 1000);
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL beat_timeout: got tready=0 for %0d cycles, expected acceptance", t);
      end
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (sbq.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_drain_timeout: got %0d words outstanding, expected 0", name, sbq.size());
         sbq.delete();
      end
      repeat (2) @(posedge clk);
      #1;
      check({name, "_err_tlast"}, err_tlast, err_exp);
   endtask

   task automatic run_frame(input string name, input int w, input int h, input int abort_idx,
                            input bit final_tlast, input bit bubbles, input bit scramble);
      int n;
      cfg_width  = CW'(w);
      cfg_height = RW'(h);
      push_expected(w, h, abort_idx, final_tlast);
      n = (abort_idx >= 0) ? abort_idx + 1 : w*h;
      for (int k = 0; k < n; k++) begin
         if (bubbles && $urandom_range(0, 2) == 0)
            send_beat(16'($urandom), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
         send_beat(16'(px[k]), 2'b11, (k == abort_idx) || (k == w*h-1 && final_tlast));
         if (k == 0 && scramble) begin
            cfg_width  = CW'(2 * $urandom_range(1, 100));
            cfg_height = RW'(2 * $urandom_range(1, 100));
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      wait_drain(name);
   endtask

   task automatic load_seq(input int n);
      for (int k = 0; k < n; k++) px[k] = k + 1;
   endtask

   initial begin
      int w, h, ab;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", m_tvalid, 1'b0);
      check("rst_tlast",  m_tlast,  1'b0);
      check("rst_tdata",  m_tdata,  16'h0000);
      check("rst_err",    err_tlast, 1'b0);
      check("rst_state",  dut.state, IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_tready", s_tready, 1'b1);

      load_seq(16);
      run_frame("seq4x4", 4, 4, -1, 1'b1, 1'b0, 1'b0);

      bp_mode = 1;
      load_seq(16);
      run_frame("seq4x4_bp", 4, 4, -1, 1'b1, 1'b0, 1'b0);
      bp_mode = 0;

      px[0] = -5; px[1] = -3; px[2] = -7; px[3] = -9;
      run_frame("neg2x2", 2, 2, -1, 1'b1, 1'b0, 1'b0);

      load_seq(16);
      run_frame("early_last", 4, 4, 8, 1'b1, 1'b0, 1'b0);
      load_seq(4);
      run_frame("after_err", 2, 2, -1, 1'b1, 1'b0, 1'b0);

      // Reset arrives while pixel 6 is on the bus.
      cfg_width = CW'(4); cfg_height = RW'(4);
      for (int k = 0; k < 5; k++) send_beat(16'(k + 1), 2'b11, 1'b0);
      s_tdata = 16'd6; s_tkeep = 2'b11; s_tlast = 1'b0; s_tvalid = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_tvalid", m_tvalid, 1'b0);
      check("midrst_state",  dut.state, IDLE);
      check("midrst_err",    err_tlast, 1'b0);
      s_tvalid = 1'b0;
      sbq.delete();
      err_exp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      px[0] = 4; px[1] = 1; px[2] = 1; px[3] = 1;
      run_frame("post_rst", 2, 2, -1, 1'b1, 1'b0, 1'b0);

      load_seq(16);
      run_frame("bubbles", 4, 4, -1, 1'b1, 1'b1, 1'b0);

      load_seq(16);
      run_frame("no_final_last", 4, 4, -1, 1'b0, 1'b0, 1'b0);

      bp_mode = 2;
      for (int f = 0; f < 10; f++) begin
         w = 2 * $urandom_range(1, 4);
         h = 2 * $urandom_range(1, 4);
         for (int k = 0; k < w*h; k++) px[k] = int'($urandom_range(0, 65535)) - 32768;
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w*h - 2)) : -1;
         run_frame("rand", w, h, ab, ($urandom_range(0, 4) != 0),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
      end
      bp_mode = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
